// File: rtl/m_mem_ctrl_if.sv
// m_mem_ctrl_if: single-port data-memory bus with req/gnt/rvalid handshake
//   req/we/addr/be/wdata : request side, driven by the controller (master)
//   gnt/rvalid/rdata     : response side, driven by the memory (slave)
interface m_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/m_mem_ctrl.sv
// m_mem_ctrl: M-stage load/store controller driving a req/gnt/rvalid data-memory bus
//   clk, reset (async, active high)
//   MemRead/MemWrite/MemSize/MemAddr/MemWData : M-stage request, held stable while stall=1
//   stall       : freezes F/D/E/M until the transaction completes
//   bus         : memory bus (master side)
//   DEin/DEaddr : raw loaded word and its address low bits for the load-data extender
//   rdata_valid : one-cycle pulse when DEin has been updated
//   exc_AdEL/exc_AdES : misaligned load/store, only when M_ALIGN_CHK_EN is defined
module m_mem_ctrl (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [1:0]         MemSize,
    input  logic [31:0]        MemAddr,
    input  logic [31:0]        MemWData,
    output logic               stall,
    m_mem_ctrl_if.master       bus,
    output logic [31:0]        DEin,
    output logic [1:0]         DEaddr,
    output logic               rdata_valid,
    output logic               exc_AdEL,
    output logic               exc_AdES
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state;
    logic idle, misaligned, go;
    logic [3:0] be;
    logic [31:0] wdata;
    always_comb begin
        idle = state == IDLE;
`ifdef M_ALIGN_CHK_EN
        misaligned = MemSize == 2'b01 ? MemAddr[0] :
                     MemSize == 2'b10 ? 1'b0 : |MemAddr[1:0];
        exc_AdEL = idle & MemRead & misaligned;
        exc_AdES = idle & MemWrite & ~MemRead & misaligned;
`else
        misaligned = 1'b0;
        exc_AdEL = 1'b0;
        exc_AdES = 1'b0;
`endif
        go = idle & (MemRead | MemWrite) & ~misaligned;
        stall = go | state == REQ | state == WAIT;
        be = MemSize == 2'b01 ? (MemAddr[1] ? 4'b1100 : 4'b0011) :
             MemSize == 2'b10 ? 4'b0001 << MemAddr[1:0] : 4'b1111;
        wdata = MemSize == 2'b01 ? {2{MemWData[15:0]}} :
                MemSize == 2'b10 ? {4{MemWData[7:0]}} : MemWData;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bus.req <= 1'b0;
            bus.we <= 1'b0;
            bus.addr <= 32'h0;
            bus.be <= 4'h0;
            bus.wdata <= 32'h0;
            DEin <= 32'h0;
            DEaddr <= 2'b00;
            rdata_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    // a simultaneous load and store is issued as the load
                    bus.we <= ~MemRead;
                    bus.addr <= {MemAddr[31:2], 2'b00};
                    bus.be <= be;
                    bus.wdata <= wdata;
                    bus.req <= 1'b1;
                    if (MemRead) DEaddr <= MemAddr[1:0];
                    state <= REQ;
                end
                REQ: if (bus.gnt) begin
                    bus.req <= 1'b0;
                    state <= bus.we ? DONE : WAIT;
                end
                WAIT: if (bus.rvalid) begin
                    DEin <= bus.rdata;
                    rdata_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    rdata_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_mem_ctrl.sv
// tb_m_mem_ctrl: table-driven and randomized checks of m_mem_ctrl against a behavioural model
module tb_m_mem_ctrl;
`ifdef M_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic MemRead = 1'b0, MemWrite = 1'b0;
    logic [1:0] MemSize = 2'b00;
    logic [31:0] MemAddr = 32'h0, MemWData = 32'h0;
    logic stall, rdata_valid, exc_AdEL, exc_AdES;
    logic [31:0] DEin;
    logic [1:0] DEaddr;
    int errors = 0, checks = 0;
    logic [31:0] m_dein = 32'h0;
    logic [1:0] m_deaddr = 2'b00;

    m_mem_ctrl_if bus();

    m_mem_ctrl dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemAddr(MemAddr), .MemWData(MemWData), .stall(stall),
        .bus(bus), .DEin(DEin), .DEaddr(DEaddr), .rdata_valid(rdata_valid),
        .exc_AdEL(exc_AdEL), .exc_AdES(exc_AdES)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic mr, mw;
        logic [1:0] sz;
        logic [31:0] ad, wd;
        int gd, vd;
        logic [31:0] rdat;
        logic e_we;
        logic [31:0] e_addr;
        logic [3:0] e_be;
        logic [31:0] e_wd;
        int e_stall;
        logic [1:0] e_exc;
        logic [31:0] e_dein;
        logic [1:0] e_deaddr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outcome from the access rules: lanes covered by the naturally
    // aligned unit, data bytes repeated across lanes, latency from handshake delays.
    function automatic vec_t model(input vec_t v);
        int n, base;
        logic mis;
        n = v.sz == 2'd1 ? 2 : v.sz == 2'd2 ? 1 : 4;
        base = int'(v.ad[1:0]) / n * n;
        mis = ALIGN && (int'(v.ad[1:0]) % n != 0);
        v.e_we = v.mw && !v.mr;
        v.e_addr = v.ad & ~32'd3;
        for (int i = 0; i < 4; i++) begin
            v.e_be[i] = i >= base && i < base + n;
            v.e_wd[8*i +: 8] = v.wd[8*(i % n) +: 8];
        end
        v.e_exc = mis ? {v.mr, !v.mr} : 2'b00;
        v.e_stall = mis ? 0 : 2 + v.gd + (v.mr ? v.vd + 1 : 0);
        v.e_dein = (v.mr && !mis) ? v.rdat : m_dein;
        v.e_deaddr = (v.mr && !mis) ? v.ad[1:0] : m_deaddr;
        return v;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int stalls = 0, gc = 0, vc = 0, pulses = 0;
        bit done = 0, seen = 0, waiting = 0;
        @(negedge clk);
        MemRead = v.mr; MemWrite = v.mw; MemSize = v.sz; MemAddr = v.ad; MemWData = v.wd;
        #1;
        check({tag, " exc"}, 32'({exc_AdEL, exc_AdES}), 32'(v.e_exc));
        for (int c = 0; c < 200 && !done; c++) begin
            if (c > 0) @(negedge clk);
            bus.gnt = 1'b0;
            bus.rvalid = 1'b0;
            bus.rdata = $urandom;
            if (rdata_valid) pulses++;
            if (stall) stalls++;
            else done = 1;
            if (bus.req && !seen) begin
                seen = 1;
                check({tag, " we"}, 32'(bus.we), 32'(v.e_we));
                check({tag, " addr"}, bus.addr, v.e_addr);
                check({tag, " be"}, 32'(bus.be), 32'(v.e_be));
                if (v.e_we) check({tag, " wdata"}, bus.wdata, v.e_wd);
            end
            if (bus.req) begin
                bus.gnt = gc == v.gd;
                bus.rvalid = 1'($urandom_range(0, 1));
                gc++;
                if (bus.gnt && !v.e_we) waiting = 1;
            end else if (waiting && gc > 0 && c > 0 && !done) begin
                bus.rvalid = vc == v.vd;
                if (bus.rvalid) begin
                    bus.rdata = v.rdat;
                    waiting = 0;
                end
                vc++;
            end
        end
        check({tag, " finished"}, 32'(done), 32'd1);
        check({tag, " req"}, 32'(seen), 32'(v.e_stall != 0));
        check({tag, " stall cycles"}, stalls, v.e_stall);
        check({tag, " DEin"}, DEin, v.e_dein);
        check({tag, " DEaddr"}, 32'(DEaddr), 32'(v.e_deaddr));
        MemRead = 1'b0; MemWrite = 1'b0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
        @(negedge clk);
        if (rdata_valid) pulses++;
        check({tag, " rdata_valid pulses"}, pulses, 32'(v.mr && v.e_stall != 0));
        check({tag, " idle"}, 32'({stall, bus.req}), 32'd0);
        m_dein = v.e_dein;
        m_deaddr = v.e_deaddr;
    endtask

    vec_t tbl[8];
    vec_t r;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 2'd0, 32'h1004, 32'h12345678, 0, 0, 32'h0,
                   1'b1, 32'h1004, 4'hF, 32'h12345678, 2, 2'b00, 32'h0, 2'd0};
        tbl[1] = '{1'b0, 1'b1, 2'd2, 32'h2003, 32'hAB, 0, 0, 32'h0,
                   1'b1, 32'h2000, 4'h8, 32'hABABABAB, 2, 2'b00, 32'h0, 2'd0};
        tbl[2] = '{1'b1, 1'b0, 2'd1, 32'h3002, 32'h0, 2, 2, 32'h80017FFF,
                   1'b0, 32'h3000, 4'hC, 32'h0, 7, 2'b00, 32'h80017FFF, 2'd2};
        tbl[3] = '{1'b0, 1'b1, 2'd1, 32'h3000, 32'h0000BEEF, 1, 0, 32'h0,
                   1'b1, 32'h3000, 4'h3, 32'hBEEFBEEF, 3, 2'b00, 32'h80017FFF, 2'd2};
        tbl[4] = '{1'b1, 1'b1, 2'd0, 32'h40, 32'h0, 0, 0, 32'h11223344,
                   1'b0, 32'h40, 4'hF, 32'h0, 3, 2'b00, 32'h11223344, 2'd0};
        tbl[5] = '{1'b1, 1'b0, 2'd0, 32'h2, 32'h0, 0, 0, 32'h55667788,
                   1'b0, 32'h0, 4'hF, 32'h0, ALIGN ? 0 : 3, ALIGN ? 2'b10 : 2'b00,
                   ALIGN ? 32'h11223344 : 32'h55667788, ALIGN ? 2'd0 : 2'd2};
        tbl[6] = '{1'b1, 1'b0, 2'd2, 32'h5, 32'h0, 1, 0, 32'h0A0B0C0D,
                   1'b0, 32'h4, 4'h2, 32'h0, 4, 2'b00, 32'h0A0B0C0D, 2'd1};
        tbl[7] = '{1'b0, 1'b1, 2'd3, 32'h8, 32'hCAFEF00D, 0, 0, 32'h0,
                   1'b1, 32'h8, 4'hF, 32'hCAFEF00D, 2, 2'b00, 32'h0A0B0C0D, 2'd1};
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
        @(negedge clk);
        check("reset bus", 32'({bus.req, bus.we, bus.be}), 32'd0);
        check("reset addr/wdata", bus.addr | bus.wdata, 32'd0);
        check("reset DE", DEin | 32'(DEaddr), 32'd0);
        check("reset valid/stall", 32'({rdata_valid, stall}), 32'd0);
        reset = 1'b0;
        // reset during REQ (p=0) and during WAIT (p=1), then a stray rvalid
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            MemRead = 1'b1; MemSize = 2'd0; MemAddr = 32'h100;
            @(negedge clk);
            check("mid req", 32'(bus.req), 32'd1);
            bus.gnt = p == 1;
            if (p == 1) @(negedge clk);
            bus.gnt = 1'b0;
            check("mid stall", 32'(stall), 32'd1);
            reset = 1'b1; MemRead = 1'b0;
            #1;
            check("rst req", 32'(bus.req), 32'd0);
            check("rst stall", 32'(stall), 32'd0);
            @(negedge clk);
            reset = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF;
            @(negedge clk);
            bus.rvalid = 1'b0;
            check("late rvalid DEin", DEin, 32'h0);
            check("late rvalid valid", 32'({rdata_valid, stall}), 32'd0);
        end
        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));
        for (int k = 0; k < 40; k++) begin
            int op;
            op = $urandom_range(0, 2);
            r.mr = op != 1;
            r.mw = op != 0;
            r.sz = 2'($urandom_range(0, 3));
            r.ad = $urandom;
            r.wd = $urandom;
            r.gd = $urandom_range(0, 3);
            r.vd = $urandom_range(0, 3);
            r.rdat = $urandom;
            run(model(r), $sformatf("rnd%0d", k));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
